reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 16, register and operand width (matches ALU a/b/out).
REQ-002 Parameter NREGS, default 16, register count; address width is 4 (fixed).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rd_en  input  1  read request; samples ra_addr/rb_addr this cycle.
REQ-006 ra_addr  input  4  source register for ALU operand a.
REQ-007 rb_addr  input  4  source register for ALU operand b.
REQ-008 a  output  DATA_W  registered operand a to ALU.
REQ-009 b  output  DATA_W  registered operand b to ALU.
REQ-010 op_valid  output  1  a/b hold data from the read accepted last cycle.
REQ-011 we  input  1  write enable for ALU result writeback.
REQ-012 wr_addr  input  4  destination register.
REQ-013 wr_data  input  DATA_W  writeback data (ALU out).
REQ-014 flags_we  input  1  capture ALU status flags.
REQ-015 neg_in, zero_in, ovf_in  input  1 each  ALU neg/zero/overflow.
REQ-016 flags  output  3  registered {neg, zero, overflow}.

Function
REQ-017 Read latency SHALL be exactly 1 cycle: rd_en at edge N -> a/b valid and op_valid=1 after edge N, held until the next accepted read.
REQ-018 op_valid SHALL be 1 for exactly one cycle per accepted read; rd_en=0 -> op_valid=0 next cycle, a/b keep last values.
REQ-019 Register 0 SHALL read as 0 always; writes to address 0 SHALL be discarded.
REQ-020 we=1, wr_addr!=0 SHALL update the register at the rising edge; one write per cycle.
REQ-021 ra_addr==rb_addr SHALL return the same value on a and b.
REQ-022 flags_we=1 SHALL load {neg_in, zero_in, ovf_in} into flags at the edge; flags_we=0 holds.
REQ-023 we and flags_we SHALL be independent; both in one cycle update both.
REQ-024 Same-cycle read and write of the same nonzero address: behaviour per REQ-029/REQ-030.
REQ-025 Addresses >= NREGS (only if NREGS<16) SHALL read 0 and ignore writes.

Reset
REQ-026 rst_n=0 SHALL immediately (asynchronously) clear all registers, a, b, op_valid, flags to 0.
REQ-027 Reset asserted mid-operation SHALL abort any pending read/write; no write lands on the edge coinciding with reset.
REQ-028 After rst_n deasserts, first rd_en edge SHALL yield op_valid=1 with zero operands.

Configuration
REQ-029 REGFILE_BYPASS_EN defined: same-cycle write/read to same nonzero address SHALL forward wr_data to a and/or b (write-through).
REQ-030 REGFILE_BYPASS_EN undefined: such a read SHALL return the pre-write value; new value visible from next read.

Verification
REQ-031 Reset: rst_n=0 mid-cycle -> a=b=0, flags=3'b000, op_valid=0 without waiting for clk.
REQ-032 Write r1=170, r2=255; read ra=1, rb=2 -> next cycle a=170, b=255, op_valid=1 for one cycle.
REQ-033 Write r0=16'hFFFF, read ra=0, rb=0 -> a=0, b=0.
REQ-034 Same cycle we r3=425 and read ra=3 (r3 previously 85) -> a=425 with REGFILE_BYPASS_EN, a=85 without.
REQ-035 flags_we=1 with neg_in=1, zero_in=0, ovf_in=1 -> flags=3'b101; next cycle flags_we=0 with inputs 0 -> flags stays 3'b101.
REQ-036 rd_en held 0 for 3 cycles after a read -> op_valid=0, a/b unchanged.

Source files
------------

// File: rtl/reg_file_if.sv
// Operand-read / writeback / flags bus between the register file and its user.
interface reg_file_if #(
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned AW = 4;

  logic              rd_en;
  logic [AW-1:0]     ra_addr;
  logic [AW-1:0]     rb_addr;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              op_valid;
  logic              we;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              flags_we;
  logic              neg_in;
  logic              zero_in;
  logic              ovf_in;
  logic [2:0]        flags;

  modport master (
    output rd_en, ra_addr, rb_addr, we, wr_addr, wr_data,
           flags_we, neg_in, zero_in, ovf_in,
    input  a, b, op_valid, flags
  );

  modport slave (
    input  rd_en, ra_addr, rb_addr, we, wr_addr, wr_data,
           flags_we, neg_in, zero_in, ovf_in,
    output a, b, op_valid, flags
  );
endinterface

// File: rtl/reg_file.sv
// ALU register file: two registered read ports, one write port, status flags.
// Register 0 is hardwired to zero; addresses >= NREGS read zero, ignore writes.
// Optional macro REGFILE_BYPASS_EN: a same-cycle write to a register being
// read forwards wr_data to the operand. Undefined: the read sees the old value.
module reg_file #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 16
) (
  input logic       clk,
  input logic       rst_n,
  reg_file_if.slave bus
);
  localparam int unsigned AW    = 4;
  localparam int unsigned IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              op_valid_q;
  logic [2:0]        flags_q, flags_d;
  logic              wr_ok_c;

  // An address is backed by storage only if nonzero and below NREGS.
  function automatic logic in_range(input logic [AW-1:0] addr);
    return (addr != '0) && (32'(addr) < NREGS);
  endfunction

  assign wr_ok_c = bus.we && in_range(bus.wr_addr);

  // Next operand and flag values.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    flags_d = flags_q;
    if (bus.rd_en) begin
      a_d = '0;
      b_d = '0;
      if (in_range(bus.ra_addr)) a_d = regs_q[bus.ra_addr[IDX_W-1:0]];
      if (in_range(bus.rb_addr)) b_d = regs_q[bus.rb_addr[IDX_W-1:0]];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok_c && (bus.ra_addr == bus.wr_addr)) a_d = bus.wr_data;
      if (wr_ok_c && (bus.rb_addr == bus.wr_addr)) b_d = bus.wr_data;
`endif
    end
    if (bus.flags_we) flags_d = {bus.neg_in, bus.zero_in, bus.ovf_in};
  end

  // Storage array; entry 0 is never written and stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (wr_ok_c) begin
      regs_q[bus.wr_addr[IDX_W-1:0]] <= bus.wr_data;
    end
  end

  // Operand, valid and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      op_valid_q <= 1'b0;
      flags_q    <= '0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      op_valid_q <= bus.rd_en;
      flags_q    <= flags_d;
    end
  end

  assign bus.a        = a_q;
  assign bus.b        = b_q;
  assign bus.op_valid = op_valid_q;
  assign bus.flags    = flags_q;
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, reset sequences,
// and randomized traffic against an array-based reference model.
module tb_reg_file;
  localparam int unsigned DW = 16;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  reg_file_if #(.DATA_W(DW)) bus ();

  reg_file #(.DATA_W(DW), .NREGS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [3:0]    wa;
    logic [DW-1:0] wd;
    logic          rd;
    logic [3:0]    ra;
    logic [3:0]    rb;
    logic          fwe;
    logic [2:0]    fin;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    logic          ev;
    logic [2:0]    ef;
  } vec_t;

  vec_t tbl [14];

  // Reference model state.
  logic [DW-1:0] mem [16];
  logic [DW-1:0] m_a, m_b;
  logic          m_v;
  logic [2:0]    m_f;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                         input logic ev, input logic [2:0] ef);
    chk({nm, "_a"},     32'(bus.a),        32'(ea));
    chk({nm, "_b"},     32'(bus.b),        32'(eb));
    chk({nm, "_valid"}, 32'(bus.op_valid), 32'(ev));
    chk({nm, "_flags"}, 32'(bus.flags),    32'(ef));
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [DW-1:0] wd,
                       input logic rd, input logic [3:0] ra, input logic [3:0] rb,
                       input logic fwe, input logic [2:0] fin);
    bus.we       = we;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.rd_en    = rd;
    bus.ra_addr  = ra;
    bus.rb_addr  = rb;
    bus.flags_we = fwe;
    bus.neg_in   = fin[2];
    bus.zero_in  = fin[1];
    bus.ovf_in   = fin[0];
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) mem[i] = '0;
    m_a = '0; m_b = '0; m_v = 1'b0; m_f = '0;
  endfunction

  // Value a read of addr returns this cycle, given the write also happening now.
  function automatic logic [DW-1:0] model_read(input logic [3:0] addr, input logic we,
                                               input logic [3:0] wa, input logic [DW-1:0] wd);
    if (addr == 4'd0) return '0;
    if (BYP && we && (wa == addr)) return wd;
    return mem[addr];
  endfunction

  // One clock edge of the architectural behaviour: reads see pre-write state.
  function automatic void model_step(input logic we, input logic [3:0] wa, input logic [DW-1:0] wd,
                                     input logic rd, input logic [3:0] ra, input logic [3:0] rb,
                                     input logic fwe, input logic [2:0] fin);
    if (rd) begin
      m_a = model_read(ra, we, wa, wd);
      m_b = model_read(rb, we, wa, wd);
    end
    m_v = rd;
    if (fwe) m_f = fin;
    if (we && (wa != 4'd0)) mem[wa] = wd;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(1'b0, 4'd0, '0, 1'b0, 4'd0, 4'd0, 1'b0, 3'b000);

    //                 we   wa    wd          rd   ra    rb    fwe  fin     ea                    eb         ev   ef
    tbl[0]  = '{1'b1, 4'd1, 16'd170,    1'b0, 4'd0, 4'd0, 1'b0, 3'b000, 16'd0,                16'd0,     1'b0, 3'b000};
    tbl[1]  = '{1'b1, 4'd2, 16'd255,    1'b0, 4'd0, 4'd0, 1'b0, 3'b000, 16'd0,                16'd0,     1'b0, 3'b000};
    tbl[2]  = '{1'b0, 4'd0, 16'd0,      1'b1, 4'd1, 4'd2, 1'b0, 3'b000, 16'd170,              16'd255,   1'b1, 3'b000};
    tbl[3]  = '{1'b0, 4'd0, 16'd0,      1'b0, 4'd0, 4'd0, 1'b0, 3'b000, 16'd170,              16'd255,   1'b0, 3'b000};
    tbl[4]  = '{1'b0, 4'd0, 16'd0,      1'b0, 4'd3, 4'd4, 1'b0, 3'b000, 16'd170,              16'd255,   1'b0, 3'b000};
    tbl[5]  = '{1'b0, 4'd0, 16'd0,      1'b0, 4'd0, 4'd0, 1'b0, 3'b000, 16'd170,              16'd255,   1'b0, 3'b000};
    tbl[6]  = '{1'b1, 4'd0, 16'hFFFF,   1'b1, 4'd0, 4'd0, 1'b0, 3'b000, 16'd0,                16'd0,     1'b1, 3'b000};
    tbl[7]  = '{1'b1, 4'd3, 16'd85,     1'b0, 4'd0, 4'd0, 1'b0, 3'b000, 16'd0,                16'd0,     1'b0, 3'b000};
    tbl[8]  = '{1'b1, 4'd3, 16'd425,    1'b1, 4'd3, 4'd3, 1'b0, 3'b000, BYP ? 16'd425 : 16'd85, BYP ? 16'd425 : 16'd85, 1'b1, 3'b000};
    tbl[9]  = '{1'b0, 4'd0, 16'd0,      1'b1, 4'd3, 4'd0, 1'b0, 3'b000, 16'd425,              16'd0,     1'b1, 3'b000};
    tbl[10] = '{1'b0, 4'd0, 16'd0,      1'b0, 4'd0, 4'd0, 1'b1, 3'b101, 16'd425,              16'd0,     1'b0, 3'b101};
    tbl[11] = '{1'b0, 4'd0, 16'd0,      1'b0, 4'd0, 4'd0, 1'b0, 3'b000, 16'd425,              16'd0,     1'b0, 3'b101};
    tbl[12] = '{1'b1, 4'd5, 16'h1234,   1'b1, 4'd5, 4'd5, 1'b1, 3'b010, BYP ? 16'h1234 : 16'd0, BYP ? 16'h1234 : 16'd0, 1'b1, 3'b010};
    tbl[13] = '{1'b0, 4'd0, 16'd0,      1'b1, 4'd5, 4'd2, 1'b0, 3'b000, 16'h1234,             16'd255,   1'b1, 3'b010};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", '0, '0, 1'b0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, one clock edge per row.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].rd, tbl[i].ra, tbl[i].rb, tbl[i].fwe, tbl[i].fin);
      @(posedge clk);
      #1;
      chk_all($sformatf("row%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].ev, tbl[i].ef);
    end

    // Asynchronous reset in the middle of a cycle, with outputs nonzero.
    drive(1'b0, 4'd0, '0, 1'b1, 4'd1, 4'd2, 1'b0, 3'b000);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", '0, '0, 1'b0, 3'b000);

    // A write presented while reset is held must not land.
    drive(1'b1, 4'd1, 16'hBEEF, 1'b1, 4'd1, 4'd1, 1'b1, 3'b111);
    @(posedge clk);
    #1;
    chk_all("rst_hold", '0, '0, 1'b0, 3'b000);
    #2;
    rst_n = 1'b1;
    drive(1'b0, 4'd0, '0, 1'b1, 4'd1, 4'd2, 1'b0, 3'b000);
    @(posedge clk);
    #1;
    chk_all("first_read", '0, '0, 1'b1, 3'b000);

    // Randomized traffic against the reference model.
    model_clear();
    drive(1'b0, 4'd0, '0, 1'b0, 4'd0, 4'd0, 1'b0, 3'b000);
    @(posedge clk);
    #1;
    model_step(1'b0, 4'd0, '0, 1'b0, 4'd0, 4'd0, 1'b0, 3'b000);
    for (int n = 0; n < 400; n++) begin
      logic          we, rd, fwe;
      logic [3:0]    wa, ra, rb;
      logic [DW-1:0] wd;
      logic [2:0]    fin;
      if (n == 200) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        chk_all("rand_rst", m_a, m_b, m_v, m_f);
        #1;
        rst_n = 1'b1;
      end
      we  = 1'($urandom_range(0, 1));
      rd  = 1'($urandom_range(0, 3) != 0);
      fwe = 1'($urandom_range(0, 1));
      wa  = 4'($urandom_range(0, 7));
      ra  = 4'($urandom_range(0, 7));
      rb  = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
      wd  = DW'($urandom);
      fin = 3'($urandom);
      drive(we, wa, wd, rd, ra, rb, fwe, fin);
      model_step(we, wa, wd, rd, ra, rb, fwe, fin);
      @(posedge clk);
      #1;
      chk_all($sformatf("rand%0d", n), m_a, m_b, m_v, m_f);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
